// File: rtl/panel_scan_reader_if.sv
// Memory read bus between the panel scan reader and the memory controller.
//   address_mem        word address of the read request
//   rd_mem             read request, qualified with address_mem
//   busy_mem           memory cannot accept a request this cycle
//   data_in_mem        read data
//   data_in_ready_mem  read data valid; responses return in request order
// master: the reader (issues requests). slave: the memory side.
interface panel_scan_reader_if #(
  parameter int ADDRESS_WIDTH = 25,
  parameter int DATA_WIDTH    = 16
) ();
  logic [ADDRESS_WIDTH-1:0] address_mem;
  logic                     rd_mem;
  logic                     busy_mem;
  logic [DATA_WIDTH-1:0]    data_in_mem;
  logic                     data_in_ready_mem;

  modport master (
    output address_mem, rd_mem,
    input  busy_mem, data_in_mem, data_in_ready_mem
  );

  modport slave (
    input  address_mem, rd_mem,
    output busy_mem, data_in_mem, data_in_ready_mem
  );
endinterface

// File: rtl/panel_scan_reader.sv
// HUB75 panel scan reader.
// Walks the selected frame buffer one row pair at a time (upper half row and
// the matching lower half row), fetches each pixel pair over the memory read
// bus, decodes it to 1 bit per colour channel and shifts it into the panel,
// then latches the row and lights it for ON_CYCLES clocks.
// Ports:
//   clk_sys, reset          clock, synchronous active-high reset
//   mem                     memory read bus (master side)
//   frame_buffer_select     0 = FB0 at word 0, 1 = FB1 at FB1_BASE
//   color_format            0 = RGB332 in data[7:0], 1 = RGB565
//   pixels_per_row          columns per row, 0 disables scanning
//   panel_rows              scan rows per half panel, 0 disables scanning
//   r0,g0,b0 / r1,g1,b1     upper / lower half colour bits
//   panel_clk, panel_lat    shift clock and latch strobe
//   panel_oe_n              output enable, active low
//   row_addr                scan row address (A-D)
//   frame_done              one-cycle pulse after the last row's display
module panel_scan_reader #(
  parameter int                       ADDRESS_WIDTH = 25,
  parameter int                       DATA_WIDTH    = 16,
  parameter logic [ADDRESS_WIDTH-1:0] FB1_BASE      = 25'h0100000,
  parameter int                       ON_CYCLES     = 256
) (
  input  logic                clk_sys,
  input  logic                reset,
  panel_scan_reader_if.master mem,
  input  logic                frame_buffer_select,
  input  logic                color_format,
  input  logic [9:0]          pixels_per_row,
  input  logic [3:0]          panel_rows,
  output logic                r0,
  output logic                g0,
  output logic                b0,
  output logic                r1,
  output logic                g1,
  output logic                b1,
  output logic                panel_clk,
  output logic                panel_lat,
  output logic                panel_oe_n,
  output logic [3:0]          row_addr,
  output logic                frame_done
);

  localparam int AW   = ADDRESS_WIDTH;
  localparam int ON_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
  localparam logic [ON_W-1:0] ON_LAST = ON_W'(ON_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_REQ_U, S_REQ_L, S_WAIT,
    S_SHIFT_LO, S_SHIFT_HI, S_LATCH, S_DISPLAY
  } state_t;

  state_t          state_q;
  logic            fmt_q;
  logic [9:0]      ppr_q;
  logic [3:0]      rows_q;
  logic [AW-1:0]   base_q, half_off_q, row_base_q, addr_q;
  logic [9:0]      col_q;
  logic [3:0]      row_q, setup_cnt_q, row_addr_q;
  logic [ON_W-1:0] on_cnt_q;
  logic [1:0]      outst_q, got_q;
  logic [2:0]      rgb_u_q, rgb_l_q, out_u_q, out_l_q;
  logic            rd_q, clk_q, lat_q, oe_n_q, done_q;

  // Colour extraction: the tap vector holds the RGB565 bits {15,10,4} and the
  // RGB332 bits {7,4,1}; the format bit picks one triple.
  function automatic logic [2:0] rgb_decode(input logic fmt, input logic [5:0] tap);
    return fmt ? tap[5:3] : tap[2:0];
  endfunction

  logic [5:0] tap;
  logic [2:0] resp_rgb, lower_now;
  logic       accept, in_resp_window, resp_ok, pair_done;
  logic       unused_data_bits;

  assign tap = {mem.data_in_mem[15], mem.data_in_mem[10], mem.data_in_mem[4],
                mem.data_in_mem[7],  mem.data_in_mem[4],  mem.data_in_mem[1]};
  assign unused_data_bits = ^{mem.data_in_mem[14:11], mem.data_in_mem[9:8],
                              mem.data_in_mem[6:5], mem.data_in_mem[3:2],
                              mem.data_in_mem[0]};
  assign resp_rgb = rgb_decode(fmt_q, tap);

  assign accept = rd_q & ~mem.busy_mem;

  // A response is only taken while a request of this pixel pair is in flight
  // (or is being accepted this very cycle, for zero-latency memories). After a
  // reset the outstanding count is zero, so stale responses fall through.
  assign in_resp_window = (state_q == S_REQ_L) || (state_q == S_WAIT) ||
                          ((state_q == S_REQ_U) && accept);
  assign resp_ok   = mem.data_in_ready_mem & in_resp_window &
                     ((outst_q != 2'd0) | accept);
  assign pair_done = (got_q == 2'd2) || ((got_q == 2'd1) && resp_ok);
  assign lower_now = ((got_q == 2'd1) && resp_ok) ? resp_rgb : rgb_l_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      fmt_q       <= 1'b0;
      ppr_q       <= '0;
      rows_q      <= '0;
      outst_q     <= '0;
      got_q       <= '0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      clk_q       <= 1'b0;
      lat_q       <= 1'b0;
      oe_n_q      <= 1'b1;
      done_q      <= 1'b0;
      row_addr_q  <= '0;
      out_u_q     <= '0;
      out_l_q     <= '0;
    end else begin
      done_q  <= 1'b0;
      outst_q <= outst_q + 2'(accept) - 2'(resp_ok);
      if (resp_ok) begin
        if (got_q == 2'd0) rgb_u_q <= resp_rgb;
        else               rgb_l_q <= resp_rgb;
        got_q <= got_q + 2'd1;
      end

      case (state_q)
        S_IDLE: begin
          // Configuration is frozen here for the whole frame.
          fmt_q       <= color_format;
          ppr_q       <= pixels_per_row;
          rows_q      <= panel_rows;
          base_q      <= frame_buffer_select ? FB1_BASE : '0;
          half_off_q  <= '0;
          setup_cnt_q <= '0;
          if (pixels_per_row != 10'd0 && panel_rows != 4'd0) state_q <= S_SETUP;
        end
        S_SETUP: begin
          // half_offset = ppr * rows, built by repeated addition.
          half_off_q  <= half_off_q + AW'(ppr_q);
          setup_cnt_q <= setup_cnt_q + 4'd1;
          if (setup_cnt_q == rows_q - 4'd1) begin
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= base_q;
            addr_q     <= base_q;
            rd_q       <= 1'b1;
            state_q    <= S_REQ_U;
          end
        end
        S_REQ_U: begin
          if (accept) begin
            addr_q  <= row_base_q + half_off_q + AW'(col_q);
            state_q <= S_REQ_L;
          end
        end
        S_REQ_L: begin
          if (accept) begin
            rd_q    <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (pair_done) begin
            out_u_q <= rgb_u_q;
            out_l_q <= lower_now;
            got_q   <= '0;
            state_q <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          clk_q   <= 1'b1;
          state_q <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          clk_q <= 1'b0;
          if (col_q == ppr_q - 10'd1) begin
            lat_q      <= 1'b1;
            row_addr_q <= row_q;
            state_q    <= S_LATCH;
          end else begin
            col_q   <= col_q + 10'd1;
            addr_q  <= row_base_q + AW'(col_q) + AW'(1);
            rd_q    <= 1'b1;
            state_q <= S_REQ_U;
          end
        end
        S_LATCH: begin
          lat_q    <= 1'b0;
          oe_n_q   <= 1'b0;
          on_cnt_q <= '0;
          state_q  <= S_DISPLAY;
        end
        S_DISPLAY: begin
          on_cnt_q <= on_cnt_q + ON_W'(1);
          if (on_cnt_q == ON_LAST) begin
            oe_n_q <= 1'b1;
            if (row_q == rows_q - 4'd1) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              row_q      <= row_q + 4'd1;
              row_base_q <= row_base_q + AW'(ppr_q);
              addr_q     <= row_base_q + AW'(ppr_q);
              col_q      <= '0;
              rd_q       <= 1'b1;
              state_q    <= S_REQ_U;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.rd_mem      = rd_q;
  assign mem.address_mem = addr_q;
  assign {r0, g0, b0}    = out_u_q;
  assign {r1, g1, b1}    = out_l_q;
  assign panel_clk       = clk_q;
  assign panel_lat       = lat_q;
  assign panel_oe_n      = oe_n_q;
  assign row_addr        = row_addr_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_panel_scan_reader.sv
// Bench for panel_scan_reader: memory model with zero-latency, random-latency
// and manual response modes, an output monitor, and a frame-level reference
// model that derives read addresses and shifted pixels from the frame layout.
module tb_panel_scan_reader;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int ON = 16;
  localparam logic [AW-1:0] FB1 = 25'h0100000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic       fbs = 1'b0, fmt = 1'b0;
  logic [9:0] ppr = '0;
  logic [3:0] rows = '0;
  logic r0, g0, b0, r1, g1, b1, panel_clk, panel_lat, panel_oe_n, frame_done;
  logic [3:0] row_addr;

  panel_scan_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  panel_scan_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .FB1_BASE(FB1), .ON_CYCLES(ON)) dut (
    .clk_sys(clk_sys), .reset(reset), .mem(mem_if),
    .frame_buffer_select(fbs), .color_format(fmt),
    .pixels_per_row(ppr), .panel_rows(rows),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .panel_clk(panel_clk), .panel_lat(panel_lat), .panel_oe_n(panel_oe_n),
    .row_addr(row_addr), .frame_done(frame_done)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mode = 0;      // 0 zero latency, 1 random latency, 2 manual
  int          pat  = 0;      // 0 addr[7:0], 1 constant word, 2 hash
  bit          rand_busy = 0;
  logic [15:0] const_word = '0;
  logic        man_rdy = 1'b0, lat_rdy = 1'b0;
  logic [15:0] man_dat = '0, lat_dat = '0;
  logic [AW-1:0] pend[$];

  function automatic logic [15:0] word_of(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {7'd0, a} * 32'd40503;
    case (pat)
      0:       return {8'h00, a[7:0]};
      1:       return const_word;
      default: return x[23:8] ^ x[15:0];
    endcase
  endfunction

  function automatic logic [2:0] dec(input logic f, input logic [15:0] w);
    return f ? {w[15], w[10], w[4]} : {w[7], w[4], w[1]};
  endfunction

  always_comb begin
    mem_if.data_in_ready_mem = 1'b0;
    mem_if.data_in_mem       = '0;
    case (mode)
      0: begin
        mem_if.data_in_ready_mem = mem_if.rd_mem & ~mem_if.busy_mem;
        mem_if.data_in_mem       = word_of(mem_if.address_mem);
      end
      1: begin
        mem_if.data_in_ready_mem = lat_rdy;
        mem_if.data_in_mem       = lat_dat;
      end
      default: begin
        mem_if.data_in_ready_mem = man_rdy;
        mem_if.data_in_mem       = man_dat;
      end
    endcase
  end

  always @(negedge clk_sys) begin
    lat_rdy = 1'b0;
    if (mode == 1 && !reset) begin
      if (mem_if.rd_mem && !mem_if.busy_mem) pend.push_back(mem_if.address_mem);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        lat_rdy = 1'b1;
        lat_dat = word_of(pend.pop_front());
      end
    end
  end

  // ---------------- monitor ----------------
  logic [AW-1:0] acc_q[$];
  logic [5:0]    pix_q[$];
  logic [3:0]    lat_q[$];
  logic          lat_oe_q[$];
  int            oe_q[$];
  int            oe_run = 0;

  always @(negedge clk_sys) begin
    if (reset) oe_run = 0;
    else begin
      if (mem_if.rd_mem && !mem_if.busy_mem) acc_q.push_back(mem_if.address_mem);
      if (panel_clk) pix_q.push_back({r0, g0, b0, r1, g1, b1});
      if (panel_lat) begin
        lat_q.push_back(row_addr);
        lat_oe_q.push_back(panel_oe_n);
      end
      if (!panel_oe_n) oe_run++;
      else if (oe_run > 0) begin
        oe_q.push_back(oe_run);
        oe_run = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
    if (rand_busy) mem_if.busy_mem = ($urandom_range(0, 3) == 0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_oe_n"}, panel_oe_n, 1);
    chk({name, "_zero"}, {mem_if.rd_mem, mem_if.address_mem, r0, g0, b0, r1, g1, b1,
                          panel_clk, panel_lat, row_addr, frame_done}, 0);
  endtask

  // Reference: pixel (r,c) of the upper half lives at base + r*ppr + c, the
  // matching lower-half pixel at base + (rows + r)*ppr + c.
  task automatic check_frame(input bit f_sel, input bit f_fmt, input int p, input int n);
    logic [AW-1:0] base, au, al;
    base = f_sel ? FB1 : '0;
    chk("read_count", acc_q.size(), 2 * p * n);
    chk("pulse_count", pix_q.size(), p * n);
    chk("latch_count", lat_q.size(), n);
    chk("display_count", oe_q.size(), n);
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < p; c++) begin
        int k;
        k  = r * p + c;
        au = AW'(base + AW'(r * p + c));
        al = AW'(base + AW'((n + r) * p + c));
        if (2 * k + 1 < acc_q.size()) begin
          chk($sformatf("addr_u r%0d c%0d", r, c), acc_q[2 * k], au);
          chk($sformatf("addr_l r%0d c%0d", r, c), acc_q[2 * k + 1], al);
        end
        if (k < pix_q.size())
          chk($sformatf("pixel r%0d c%0d", r, c), pix_q[k],
              {dec(f_fmt, word_of(au)), dec(f_fmt, word_of(al))});
      end
      if (r < lat_q.size()) begin
        chk($sformatf("row_addr r%0d", r), lat_q[r], r);
        chk($sformatf("oe_at_latch r%0d", r), lat_oe_q[r], 1);
      end
      if (r < oe_q.size()) chk($sformatf("on_cycles r%0d", r), oe_q[r], ON);
    end
  endtask

  task automatic start_frame(input bit f_sel, input bit f_fmt, input int p, input int n);
    acc_q.delete(); pix_q.delete(); lat_q.delete(); lat_oe_q.delete(); oe_q.delete();
    pend.delete();
    mem_if.busy_mem = 1'b0;
    fbs = f_sel; fmt = f_fmt; ppr = 10'(p); rows = 4'(n);
  endtask

  task automatic finish_frame(input bit f_sel, input bit f_fmt, input int p, input int n,
                              input bit flip, input bit keep);
    bit seen, flipped;
    seen = 0; flipped = 0;
    for (int i = 0; i < 30000; i++) begin
      cyc();
      if (flip && !flipped && acc_q.size() > 0) begin
        fbs = ~f_sel;
        flipped = 1;
      end
      if (frame_done) begin
        seen = 1;
        break;
      end
    end
    if (!keep) ppr = '0;
    chk("frame_done_seen", seen, 1);
    cyc();
    chk("frame_done_width", frame_done, 0);
    check_frame(f_sel, f_fmt, p, n);
  endtask

  typedef struct {
    bit fsel; bit ffmt; int p; int n; int md; bit rb; int pt;
    logic [AW-1:0] exp_first; int exp_reads;
  } frame_vec_t;

  typedef struct {
    bit ffmt; logic [15:0] w; logic [2:0] exp;
  } dec_vec_t;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_vec_t fv[5];
    dec_vec_t   dv[7];
    int         bad_rd, bad_oe;
    bit         found;

    fv[0] = '{0, 0, 4, 2,  0, 0, 0, '0,  16};
    fv[1] = '{1, 1, 3, 1,  0, 0, 2, FB1, 6};
    fv[2] = '{0, 0, 1, 1,  1, 1, 2, '0,  2};
    fv[3] = '{1, 0, 5, 3,  1, 1, 2, FB1, 30};
    fv[4] = '{0, 1, 2, 15, 1, 1, 2, '0,  60};

    dv[0] = '{1, 16'h8410, 3'b111};
    dv[1] = '{1, 16'h7BEF, 3'b000};
    dv[2] = '{0, 16'h0092, 3'b111};
    dv[3] = '{0, 16'hFF6D, 3'b000};
    dv[4] = '{1, 16'h8000, 3'b100};
    dv[5] = '{0, 16'h0002, 3'b001};
    dv[6] = '{1, 16'h0400, 3'b010};

    mem_if.busy_mem = 1'b0;
    repeat (3) cyc();
    chk_reset_outputs("reset_state");
    reset = 1'b0;

    // Disabled configurations never start a scan.
    ppr = 10'd0; rows = 4'd2;
    bad_rd = 0; bad_oe = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (mem_if.rd_mem) bad_rd++;
      if (!panel_oe_n) bad_oe++;
    end
    ppr = 10'd3; rows = 4'd0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (mem_if.rd_mem) bad_rd++;
      if (!panel_oe_n) bad_oe++;
    end
    chk("disabled_rd_cycles", bad_rd, 0);
    chk("disabled_oe_low_cycles", bad_oe, 0);
    ppr = '0; rows = '0;
    cyc();

    // Table of whole frames.
    for (int i = 0; i < 5; i++) begin
      mode = fv[i].md; pat = fv[i].pt; rand_busy = fv[i].rb;
      start_frame(fv[i].fsel, fv[i].ffmt, fv[i].p, fv[i].n);
      finish_frame(fv[i].fsel, fv[i].ffmt, fv[i].p, fv[i].n, 0, 0);
      rand_busy = 0; mem_if.busy_mem = 1'b0;
      chk($sformatf("tab%0d_reads", i), acc_q.size(), fv[i].exp_reads);
      if (acc_q.size() > 0) chk($sformatf("tab%0d_first", i), acc_q[0], fv[i].exp_first);
      repeat (2) cyc();
    end

    // Decode table: single-pixel frames returning a fixed word.
    for (int i = 0; i < 7; i++) begin
      mode = 0; pat = 1; const_word = dv[i].w;
      start_frame(0, dv[i].ffmt, 1, 1);
      finish_frame(0, dv[i].ffmt, 1, 1, 0, 0);
      if (pix_q.size() > 0)
        chk($sformatf("decode %0h fmt%0d", dv[i].w, dv[i].ffmt), pix_q[0], {dv[i].exp, dv[i].exp});
      repeat (2) cyc();
    end

    // Back-pressure while the lower-half request is pending.
    mode = 0; pat = 2;
    start_frame(0, 0, 2, 1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (mem_if.rd_mem && mem_if.address_mem == 25'd2) begin
        found = 1;
        break;
      end
    end
    chk("bp_reached_req_l", found, 1);
    mem_if.busy_mem = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_rd_hold%0d", i), mem_if.rd_mem, 1);
      chk($sformatf("bp_addr_hold%0d", i), mem_if.address_mem, 2);
    end
    mem_if.busy_mem = 1'b0;
    finish_frame(0, 0, 2, 1, 0, 0);
    repeat (2) cyc();

    // Buffer flip mid-frame takes effect on the following frame only.
    mode = 0; pat = 2;
    start_frame(0, 0, 3, 2);
    finish_frame(0, 0, 3, 2, 1, 1);
    start_frame(1, 0, 3, 2);
    finish_frame(1, 0, 3, 2, 0, 0);
    if (acc_q.size() > 0) chk("flip_next_first", acc_q[0], FB1);
    repeat (2) cyc();

    // Reset while waiting on responses; a late response must be dropped.
    mode = 2; man_rdy = 1'b0;
    start_frame(0, 0, 1, 1);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (acc_q.size() == 2 && !mem_if.rd_mem) begin
        found = 1;
        break;
      end
    end
    chk("rst_reached_wait", found, 1);
    cyc();
    reset = 1'b1; ppr = '0;
    cyc();
    chk_reset_outputs("reset_mid_frame");
    reset = 1'b0;
    cyc();
    man_dat = 16'hFFFF; man_rdy = 1'b1;
    cyc();
    man_rdy = 1'b0;
    cyc();
    mode = 0; pat = 0;
    start_frame(0, 0, 1, 1);
    finish_frame(0, 0, 1, 1, 0, 0);
    if (acc_q.size() > 0) chk("restart_first_addr", acc_q[0], 0);
    if (pix_q.size() > 0) chk("restart_pixel", pix_q[0], 6'b000000);
    repeat (2) cyc();

    // Random frames against the reference model.
    for (int i = 0; i < 16; i++) begin
      bit rs, rf;
      int rp, rn;
      rs = 1'($urandom_range(0, 1)); rf = 1'($urandom_range(0, 1));
      rp = $urandom_range(1, 8);     rn = $urandom_range(1, 4);
      mode = $urandom_range(0, 1);   pat = 2;
      rand_busy = 1'($urandom_range(0, 1));
      start_frame(rs, rf, rp, rn);
      finish_frame(rs, rf, rp, rn, 0, 0);
      rand_busy = 0; mem_if.busy_mem = 1'b0;
      repeat (2) cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/panel_scan_reader.md
Name: panel_scan_reader

Overview:
- Reader side of the frame buffer that the host command path writes into.
- Scans the active frame buffer row pair by row pair and issues in-order read requests to the memory interface.
- Converts the returned pixel words to 1-bit-per-channel HUB75 signals and generates the shift clock, latch, output-enable and row address.
- Sits between the memory controller and the LED panel connector; takes its configuration registers from the command decoder.

Parameters:
- ADDRESS_WIDTH, 25, memory word address width.
- DATA_WIDTH, 16, memory word width.
- FB1_BASE, 25'h0100000, word address of frame buffer 1 (frame buffer 0 base is 0).
- ON_CYCLES, 256, clk_sys cycles oe_n is held low per scan row.

Ports:
- clk_sys  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- frame_buffer_select  in  1  0 = FB0, 1 = FB1.
- color_format  in  1  0 = RGB332 in data[7:0], 1 = RGB565.
- pixels_per_row  in  10  columns per row; 0 disables scanning.
- panel_rows  in  4  scan rows per half-panel; 0 disables scanning.
- address_mem  out  ADDRESS_WIDTH  read word address.
- rd_mem  out  1  read request, qualified with address_mem.
- busy_mem  in  1  memory cannot accept a request this cycle.
- data_in_mem  in  DATA_WIDTH  read data.
- data_in_ready_mem  in  1  read data valid; responses return in request order.
- r0, g0, b0, r1, g1, b1  out  1 each  upper and lower half colour bits.
- panel_clk  out  1  shift clock.
- panel_lat  out  1  latch strobe.
- panel_oe_n  out  1  output enable, active low.
- row_addr  out  4  scan row address (A–D).
- frame_done  out  1  one-cycle pulse when the last row's display period ends.

Behaviour:
- Reset: all outputs 0 except panel_oe_n = 1; FSM enters IDLE; outstanding counter cleared. Reset mid-frame aborts immediately and drops all in-flight responses.
- Config latch: in IDLE, frame_buffer_select, color_format, pixels_per_row and panel_rows are sampled into shadow registers. They are held constant for the entire frame, so a flip written mid-frame takes effect at the next frame (no tearing).
- IDLE: if shadow ppr == 0 or shadow rows == 0, remain in IDLE and resample each cycle. Otherwise go to SETUP with base = FB1_BASE or 0 and half_offset = 0.
- SETUP: add ppr to half_offset once per cycle for panel_rows cycles, with no multiplier. On exit, row = 0, col = 0, row_base = base.
- REQ_U: assert rd_mem with address = row_base + col. A request is accepted in any cycle where rd_mem = 1 and busy_mem = 0. If busy_mem = 1, hold rd_mem and address_mem stable. On accept, go to REQ_L.
- REQ_L: same as REQ_U with address = row_base + half_offset + col. On accept, go to WAIT.
- WAIT: the first response is captured as the upper pixel, the second as the lower. A response may arrive in the same cycle a request is accepted. Once both are captured, drive the colour bits:
  - color_format 0: r = d[7], g = d[4], b = d[1].
  - color_format 1: r = d[15], g = d[10], b = d[4].
  - Then go to SHIFT_LO.
- SHIFT_LO: panel_clk = 0, colour bits held (one cycle of setup time). Then SHIFT_HI.
- SHIFT_HI: panel_clk = 1 for one cycle.
  - If col == ppr−1, go to LATCH.
  - Else col + 1, go to REQ_U.
- LATCH: panel_oe_n = 1 and panel_lat = 1 for one cycle; row_addr is updated to row in the same cycle. Then DISPLAY with the on-counter = 0.
- DISPLAY: panel_oe_n = 0 for exactly ON_CYCLES cycles, then:
  - If row == panel_rows−1: pulse frame_done, set panel_oe_n = 1, go to IDLE.
  - Else: row + 1, row_base += ppr, col = 0, go to REQ_U.
- Unsolicited responses: data_in_ready_mem outside WAIT/REQ_L is ignored.
- Address arithmetic: modulo 2^ADDRESS_WIDTH; wrap is permitted and not flagged.
- panel_clk, panel_lat and panel_oe_n are registered and glitch-free. panel_lat and panel_oe_n = 0 are never asserted in the same cycle.

Test Plan:
- Disabled: ppr = 0, rows = 2 -> rd_mem stays 0 for 1000 cycles; panel_oe_n = 1.
- Basic frame: FB0, ppr = 4, rows = 2, format 0, zero-latency memory returning data = address[7:0] -> read addresses in order 0, 8, 1, 9, 2, 10, 3, 11, then 4, 12, … 7, 15. Exactly 4 panel_clk pulses per row; row_addr 0 then 1; frame_done after the second DISPLAY.
- RGB565 decode: format 1, word 16'h8410 -> r = 1, g = 1, b = 1; word 16'h7BEF -> r = g = b = 0.
- Back-pressure: busy_mem high for 5 cycles during REQ_L -> address_mem and rd_mem held stable; no duplicate request; the sequence completes.
- Flip mid-frame: assert frame_buffer_select = 1 during row 0 -> remaining reads stay below FB1_BASE; the next frame's first read is FB1_BASE.
- Reset during WAIT with a response pending -> next cycle panel_oe_n = 1 and all other outputs 0; the late response is ignored; the next frame restarts at address 0.
